// File: rtl/piso_tx_if.sv
// Parallel-side handshake of the piso_tx transmitter.
// The source drives a word and a valid flag. The transmitter answers with ready.
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] p_in;
    logic             p_valid;
    logic             p_ready;

    // Word source (upstream logic or testbench)
    modport master (
        output p_in,
        output p_valid,
        input  p_ready
    );

    // Transmitter side
    modport slave (
        input  p_in,
        input  p_valid,
        output p_ready
    );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, MSB first, one bit per clock.
// A one-word holding buffer lets the next word be taken while the current word
// shifts, so back-to-back words leave with no idle bit between them.
// Every output is a decode of registered state only, so no input reaches an
// output through combinational logic.
module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    piso_tx_if.slave bus,
    output logic     s_out,
    output logic     s_valid,
    output logic     s_first,
    output logic     s_last,
    output logic     busy
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    cnt;
    logic             hold_full;
    logic             accept;

    // The handshake completes when the source offers a word and the holding slot is free.
    assign bus.p_ready = !hold_full;
    assign accept      = bus.p_valid && !hold_full;

    // Transmit FSM: load or shift the word, buffer the next word, and chain words with no gap.
    // NOTE: all state here is written with <= so every register samples the
    // pre-edge values. Blocking writes would let later lines see new values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the data registers (sh, hold) are cleared as well as the
            // control flags, so a discarded word cannot leak out after reset.
            state     <= IDLE;
            sh        <= '0;
            hold      <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh    <= bus.p_in;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (cnt != LAST) begin
                        // Mid-word: advance one bit. A new word parks in hold.
                        sh  <= sh << 1;
                        cnt <= cnt + 1'b1;
                        if (accept) begin
                            hold      <= bus.p_in;
                            hold_full <= 1'b1;
                        end
                    end else if (hold_full) begin
                        // Last bit, buffered word waiting: chain it in with no gap.
                        // p_ready is low here, so no accept can occur.
                        sh        <= hold;
                        hold_full <= 1'b0;
                        cnt       <= '0;
                    end else if (accept) begin
                        // Last bit with an empty buffer: the new word goes straight to sh.
                        sh  <= bus.p_in;
                        cnt <= '0;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Serial outputs. Data is forced low outside valid bits.
    assign s_valid = (state == SHIFT);
    assign s_out   = s_valid & sh[WIDTH-1];
    assign s_first = s_valid & (cnt == '0);
    assign s_last  = s_valid & (cnt == LAST);
    assign busy    = s_valid | hold_full;

endmodule
